// File: rtl/popcount_pkg.sv
// Shared constants for the serial popcount matcher: compare modes and FSM state encoding.
package popcount_pkg;

   localparam logic [1:0] MODE_EQ  = 2'b00;
   localparam logic [1:0] MODE_GE  = 2'b01;
   localparam logic [1:0] MODE_LE  = 2'b10;
   localparam logic [1:0] MODE_ODD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/popcount_matcher_chunk_popcount.sv
// Combinational ones-count of one CHUNK-bit slice; the per-beat adder input of the matcher.
module chunk_popcount #(
   parameter  int CHUNK = 1,
   localparam int PW    = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] bits,
   output logic [PW-1:0]    count
);

   // NOTE: always_comb uses blocking '=' and assigns every output a default first, so no latch is inferred.
   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count = count + PW'(bits[i]);
      end
   end

endmodule

// File: rtl/popcount_matcher.sv
// Streaming popcount: accepts a word, counts CHUNK bits per clock, then presents the
// count and a mode-selected compare result until the consumer takes it.
module popcount_matcher
   import popcount_pkg::*;
#(
   parameter  int WIDTH = 7,
   parameter  int CHUNK = 1,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CW-1:0]    in_target,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_match
);

   localparam int NB = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int NW = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW = $clog2(CHUNK + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    tgt_q, tgt_d;
   logic [1:0]       mode_q, mode_d;
   logic [NW-1:0]    n_q, n_d;
   logic             match_q, match_d;
   logic [PW-1:0]    chunk_cnt;
   logic [CW-1:0]    acc_next;
   logic             cmp;
   logic             accept;

   chunk_popcount #(.CHUNK(CHUNK)) u_chunk (
      .bits  (sh_q[CHUNK-1:0]),
      .count (chunk_cnt)
   );

   assign acc_next = acc_q + CW'(chunk_cnt);
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking '<='; reset is synchronous, so it lives inside the clocked branch.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)      state_d = S_COUNT;
         S_COUNT: if (n_q == '0)   state_d = S_DONE;
         S_DONE:  if (out_ready)   state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are masked by rst so nothing is offered or accepted while it is held.
   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = (state_q == S_DONE) && !rst;
      out_count = acc_q;
      out_match = match_q;
   end

   // Compare against the final accumulation so the match flag is ready when DONE is entered.
   always_comb begin
      case (mode_q)
         MODE_EQ:  cmp = (acc_next == tgt_q);
         MODE_GE:  cmp = (acc_next >= tgt_q);
         MODE_LE:  cmp = (acc_next <= tgt_q);
         default:  cmp = acc_next[0];
      endcase
   end

   always_comb begin
      sh_d    = sh_q;
      acc_d   = acc_q;
      tgt_d   = tgt_q;
      mode_d  = mode_q;
      n_d     = n_q;
      match_d = match_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sh_d    = in_data;
               tgt_d   = in_target;
               mode_d  = in_mode;
               acc_d   = '0;
               n_d     = NW'(NB - 1);
               match_d = 1'b0;
            end
         end
         S_COUNT: begin
            acc_d = acc_next;
            sh_d  = sh_q >> CHUNK;
            if (n_q == '0) match_d = cmp;
            else           n_d     = n_q - 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: every datapath register is cleared on reset so a discarded transaction leaves no stale count or flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q    <= '0;
         acc_q   <= '0;
         tgt_q   <= '0;
         mode_q  <= '0;
         n_q     <= '0;
         match_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         tgt_q   <= tgt_d;
         mode_q  <= mode_d;
         n_q     <= n_d;
         match_q <= match_d;
      end
   end

endmodule

// File: tb/tb_popcount_matcher.sv
// Directed and streaming checks of popcount_matcher at WIDTH=7 with CHUNK=1 and CHUNK=3.
module tb_popcount_matcher;
   import popcount_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [6:0] in_data   [2];
   logic [2:0] in_target [2];
   logic [1:0] in_mode   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] out_count [2];
   logic       out_match [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   popcount_matcher #(.WIDTH(7), .CHUNK(1)) u_dut1 (
      .clk (clk), .rst (rst),
      .in_valid (in_valid[0]), .in_ready (in_ready[0]), .in_data (in_data[0]),
      .in_target (in_target[0]), .in_mode (in_mode[0]),
      .out_valid (out_valid[0]), .out_ready (out_ready[0]),
      .out_count (out_count[0]), .out_match (out_match[0])
   );

   popcount_matcher #(.WIDTH(7), .CHUNK(3)) u_dut3 (
      .clk (clk), .rst (rst),
      .in_valid (in_valid[1]), .in_ready (in_ready[1]), .in_data (in_data[1]),
      .in_target (in_target[1]), .in_mode (in_mode[1]),
      .out_valid (out_valid[1]), .out_ready (out_ready[1]),
      .out_count (out_count[1]), .out_match (out_match[1])
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_pop(input logic [6:0] d);
      int c = 0;
      for (int i = 0; i < 7; i++) c += int'(d[i]);
      return c;
   endfunction

   function automatic int ref_match(input int c, input int t, input logic [1:0] m);
      case (m)
         2'b00:   return int'(c == t);
         2'b01:   return int'(c >= t);
         2'b10:   return int'(c <= t);
         default: return c % 2;
      endcase
   endfunction

   // Called #1 after a rising edge with the DUT idle; returns #1 after the accepting edge.
   task automatic start_txn(input int d, input logic [6:0] data, input logic [2:0] tgt,
                            input logic [1:0] mode);
      bit ok = 1'b0;
      in_data[d]   = data;
      in_target[d] = tgt;
      in_mode[d]   = mode;
      in_valid[d]  = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready[d];
         @(posedge clk);
         #1;
      end
      in_valid[d] = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_result(input int d, output int lat);
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result(input int d, input string tag);
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
      check({tag, "_ready_after"}, int'(in_ready[d]), 1);
      check({tag, "_valid_after"}, int'(out_valid[d]), 0);
   endtask

   task automatic directed(input int d, input string tag, input logic [6:0] data,
                           input logic [2:0] tgt, input logic [1:0] mode,
                           input int exp_lat, input int exp_cnt, input int exp_match);
      int lat;
      start_txn(d, data, tgt, mode);
      wait_result(d, lat);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_count"}, int'(out_count[d]), exp_cnt);
      check({tag, "_match"}, int'(out_match[d]), exp_match);
      release_result(d, tag);
   endtask

   task automatic stream(input int d, input int ntx);
      logic [6:0] q_data[$];
      logic [2:0] q_tgt[$];
      logic [1:0] q_mode[$];
      int sent = 0;
      int got = 0;
      int cycles = 0;
      int stray = 0;
      bit acc_fire, out_fire;
      in_data[d]   = 7'($urandom);
      in_target[d] = 3'($urandom);
      in_mode[d]   = 2'($urandom);
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      while (got < ntx && cycles < 20000) begin
         @(negedge clk);
         acc_fire = in_valid[d] && in_ready[d];
         out_fire = out_valid[d] && out_ready[d];
         if (out_fire) begin
            if (q_data.size() == 0) begin
               check("stream_unexpected_result", 1, 0);
            end else begin
               logic [6:0] xd = q_data.pop_front();
               logic [2:0] xt = q_tgt.pop_front();
               logic [1:0] xm = q_mode.pop_front();
               check("stream_count", int'(out_count[d]), ref_pop(xd));
               check("stream_match", int'(out_match[d]), ref_match(ref_pop(xd), int'(xt), xm));
            end
            got++;
         end
         if (acc_fire) begin
            q_data.push_back(in_data[d]);
            q_tgt.push_back(in_target[d]);
            q_mode.push_back(in_mode[d]);
         end
         @(posedge clk);
         #1;
         cycles++;
         if (acc_fire) begin
            sent++;
            if (sent == ntx) begin
               in_valid[d] = 1'b0;
            end else begin
               in_data[d]   = 7'($urandom);
               in_target[d] = 3'($urandom);
               in_mode[d]   = 2'($urandom);
            end
         end
         out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      check("stream_results", got, ntx);
      check("stream_sent", sent, ntx);
      check("stream_leftover", q_data.size(), 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid[d]) stray++;
      end
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
      check("stream_stray_results", stray, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, held_cnt, held_match, stray;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         in_target[d] = '0;
         in_mode[d]   = '0;
         out_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", int'(in_ready[0]), 0);
      check("reset_out_valid", int'(out_valid[0]), 0);
      check("reset_out_count", int'(out_count[0]), 0);
      check("reset_out_match", int'(out_match[0]), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_in_ready", int'(in_ready[0]), 1);

      directed(0, "eq4_hit",  7'b1011001, 3'd4, MODE_EQ,  7, 4, 1);
      directed(0, "eq3_miss", 7'b1011001, 3'd3, MODE_EQ,  7, 4, 0);
      directed(0, "ge7",      7'b1111111, 3'd7, MODE_GE,  7, 7, 1);
      directed(0, "le6",      7'b1111111, 3'd6, MODE_LE,  7, 7, 0);
      directed(0, "le7",      7'b1111111, 3'd7, MODE_LE,  7, 7, 1);
      directed(0, "odd7",     7'b1111111, 3'd0, MODE_ODD, 7, 7, 1);
      directed(0, "zero_eq0", 7'b0000000, 3'd0, MODE_EQ,  7, 0, 1);
      directed(0, "zero_odd", 7'b0000000, 3'd5, MODE_ODD, 7, 0, 0);
      directed(1, "c3_two",   7'b1000001, 3'd2, MODE_EQ,  3, 2, 1);
      directed(1, "c3_all",   7'b1111111, 3'd6, MODE_GE,  3, 7, 1);
      directed(1, "c3_top",   7'b1000000, 3'd0, MODE_ODD, 3, 1, 1);

      // Backpressure: result must hold steady while out_ready stays low.
      start_txn(0, 7'b0110110, 3'd5, MODE_LE);
      wait_result(0, lat);
      check("bp_latency", lat, 7);
      held_cnt   = int'(out_count[0]);
      held_match = int'(out_match[0]);
      check("bp_count", held_cnt, 4);
      check("bp_match", held_match, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid_held", int'(out_valid[0]), 1);
         check("bp_count_held", int'(out_count[0]), 4);
         check("bp_match_held", int'(out_match[0]), 1);
         check("bp_in_ready_low", int'(in_ready[0]), 0);
      end
      release_result(0, "bp");

      // Reset in the middle of counting discards the word.
      start_txn(0, 7'b1111111, 3'd7, MODE_EQ);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("midrst_out_valid", int'(out_valid[0]), 0);
         check("midrst_out_count", int'(out_count[0]), 0);
         check("midrst_in_ready", int'(in_ready[0]), 0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_in_ready_after", int'(in_ready[0]), 1);
      out_ready[0] = 1'b1;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid[0]) stray++;
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      check("midrst_no_stale_result", stray, 0);

      stream(0, 200);
      stream(1, 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
